// File: rtl/sw_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package sw_pkg;

  localparam int SW_WIDTH              = 10;
  localparam int SW_DEB_CYCLES_DEFAULT = 50000;
  localparam int SW_DEB_CYCLES_SIM     = 4;

  // Counter width able to hold 0 .. n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n < 1) begin
      return 1;
    end
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit switch conditioner: 2-flop synchronizer, stable-time counter
// and optional registered edge pulses (enabled by SW_DEBOUNCE_EDGE_EN).
module sw_debounce_bit #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic active
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             db_q, db_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer shift, disagreement counter and acceptance of the new level.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    active_d = (cnt_d != '0);
  end

  // State registers; reset discards any pending transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign db     = db_q;
  assign active = active_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Pulse in the first cycle the debounced level shows its new value.
  always_comb begin
    rise_d = db_d & ~db_q;
    fall_d = ~db_d & db_q;
  end

  // Edge pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debouncer.sv
// Debounces the raw slide-switch bus; WIDTH independent bit conditioners.
// Edge pulses on sw_rise/sw_fall exist only when SW_DEBOUNCE_EDGE_EN is
// defined, otherwise those ports are held at zero.
module sw_debouncer
  import sw_pkg::*;
#(
  parameter int WIDTH      = SW_WIDTH,
  parameter int DEB_CYCLES = SW_DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = cnt_width(DEB_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             busy
);

  logic [WIDTH-1:0] active;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_raw[g]),
      .db    (sw_db[g]),
      .rise  (sw_rise[g]),
      .fall  (sw_fall[g]),
      .active(active[g])
    );
  end

  // Busy while any bit has a transition in progress (per-bit flags are registered).
  always_comb begin
    busy = |active;
  end

endmodule

// File: tb/tb_sw_debouncer.sv
module tb_sw_debouncer;

  localparam int W = 10;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         busy;

  int checks = 0;
  int passes = 0;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  sw_debouncer #(
    .WIDTH     (W),
    .DEB_CYCLES(D)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronized input has
  // disagreed with it on each of the last D edges since reset / last update.
  logic [W-1:0] m_db, m_rise, m_fall;
  logic         m_busy;
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] s2_hist[$];
  int           last_upd[W];

  task automatic model_edge(input logic [W-1:0] raw_v, input logic rst_v);
    int n;
    int k;
    logic [W-1:0] s2;
    if (rst_v) begin
      raw_hist.delete();
      s2_hist.delete();
      m_db = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
      for (int i = 0; i < W; i++) last_upd[i] = 0;
      return;
    end
    raw_hist.push_back(raw_v);
    n  = raw_hist.size();
    s2 = (n >= 3) ? raw_hist[n-3] : '0;
    s2_hist.push_back(s2);
    m_rise = '0; m_fall = '0; m_busy = 1'b0;
    for (int i = 0; i < W; i++) begin
      k = 0;
      while (k < D && k < n - last_upd[i] && s2_hist[n-1-k][i] != m_db[i]) k++;
      if (k == D) begin
        if (s2[i]) m_rise[i] = 1'b1;
        else       m_fall[i] = 1'b1;
        m_db[i]     = s2[i];
        last_upd[i] = n;
      end else if (k != 0) begin
        m_busy = 1'b1;
      end
    end
  endtask

  function automatic logic [3*W:0] exp_vec();
    if (EDGE_EN) return {m_db, m_rise, m_fall, m_busy};
    return {m_db, {W{1'b0}}, {W{1'b0}}, m_busy};
  endfunction

  function automatic logic [3*W:0] dut_vec();
    return {sw_db, sw_rise, sw_fall, busy};
  endfunction

  // One clock edge; inputs change and outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(sw_raw, rst);
    @(negedge clk);
  endtask

  task automatic settle(input logic [W-1:0] v);
    rst = 1'b1; sw_raw = v; tick();
    rst = 1'b0;
    repeat (D + 4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_raw = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (dut_vec() !== '0) $display("FAIL reset_hold cyc=%0d got=%h want=0", c, dut_vec());
      else passes++;
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_release_model e=%0d got=%h want=%h", e, dut_vec(), exp_vec());
      else passes++;
      if (e == 5) begin
        checks++;
        if (sw_db !== 10'h000) $display("FAIL reset_db_early got=%h want=000", sw_db);
        else passes++;
      end
      if (e == 6) begin
        checks++;
        if (sw_db !== 10'h3FF || sw_rise !== (EDGE_EN ? 10'h3FF : 10'h000))
          $display("FAIL reset_db_6th db=%h rise=%h want db=3ff rise=%h", sw_db, sw_rise, EDGE_EN ? 10'h3FF : 10'h000);
        else passes++;
      end
      if (e == 7) begin
        checks++;
        if (sw_rise !== 10'h000) $display("FAIL reset_rise_width got=%h want=000", sw_rise);
        else passes++;
      end
    end
  endtask

  task automatic test_single_rise();
    int first, rises, falls;
    bit busy_seen;
    settle('0);
    sw_raw[0] = 1'b1;
    first = 0; rises = 0; falls = 0; busy_seen = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL rise_model e=%0d got=%h want=%h", e, dut_vec(), exp_vec());
      else passes++;
      if (sw_rise[0]) rises++;
      if (sw_fall != '0) falls++;
      if (busy) busy_seen = 1;
      if (sw_db[0] && first == 0) first = e;
    end
    checks++;
    if (first !== D + 2) $display("FAIL rise_latency got=%0d want=%0d", first, D + 2);
    else passes++;
    checks++;
    if (rises !== (EDGE_EN ? 1 : 0) || falls !== 0)
      $display("FAIL rise_pulses rises=%0d falls=%0d want %0d/0", rises, falls, EDGE_EN ? 1 : 0);
    else passes++;
    checks++;
    if (!busy_seen || busy !== 1'b0) $display("FAIL rise_busy seen=%0d final=%b want 1/0", busy_seen, busy);
    else passes++;
  endtask

  task automatic test_glitch();
    bit busy_seen, db_seen, pulse_seen;
    settle('0);
    busy_seen = 0; db_seen = 0; pulse_seen = 0;
    for (int e = 0; e < 15; e++) begin
      sw_raw[3] = (e < 3);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL glitch_model e=%0d got=%h want=%h", e, dut_vec(), exp_vec());
      else passes++;
      if (busy) busy_seen = 1;
      if (sw_db[3]) db_seen = 1;
      if (sw_rise != '0 || sw_fall != '0) pulse_seen = 1;
    end
    checks++;
    if (db_seen || pulse_seen) $display("FAIL glitch_reject db_seen=%0d pulse_seen=%0d want 0/0", db_seen, pulse_seen);
    else passes++;
    checks++;
    if (!busy_seen || busy !== 1'b0) $display("FAIL glitch_busy seen=%0d final=%b want 1/0", busy_seen, busy);
    else passes++;
  endtask

  task automatic test_simultaneous();
    int first;
    settle(10'h200);
    checks++;
    if (sw_db !== 10'h200) $display("FAIL simul_pre got=%h want=200", sw_db);
    else passes++;
    sw_raw = 10'h004;
    first = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL simul_model e=%0d got=%h want=%h", e, dut_vec(), exp_vec());
      else passes++;
      if (sw_db == 10'h004 && first == 0) begin
        first = e;
        checks++;
        if (sw_rise !== (EDGE_EN ? 10'h004 : 10'h000) || sw_fall !== (EDGE_EN ? 10'h200 : 10'h000))
          $display("FAIL simul_pulses rise=%h fall=%h", sw_rise, sw_fall);
        else passes++;
      end
    end
    checks++;
    if (first !== D + 2) $display("FAIL simul_latency got=%0d want=%0d", first, D + 2);
    else passes++;
  endtask

  task automatic test_reset_midcount();
    int first;
    settle('0);
    sw_raw[5] = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || sw_db[5] !== 1'b0) $display("FAIL midrst_pending busy=%b db5=%b want 1/0", busy, sw_db[5]);
    else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dut_vec() !== '0) $display("FAIL midrst_cleared got=%h want=0", dut_vec());
    else passes++;
    first = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL midrst_model e=%0d got=%h want=%h", e, dut_vec(), exp_vec());
      else passes++;
      if (sw_db[5] && first == 0) first = e;
    end
    checks++;
    if (first !== D + 2) $display("FAIL midrst_latency got=%0d want=%0d", first, D + 2);
    else passes++;
  endtask

  task automatic test_random();
    settle('0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 4) == 0) sw_raw = sw_raw ^ W'($urandom & $urandom);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      else passes++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw_raw = '0;
    model_edge('0, 1'b1);
    @(negedge clk);
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
